// File: rtl/ncoslew.sv
// ncoslew: modulo-N phase generator with quadrature square-wave outputs, an
// epoch pulse on wrap, and multi-step advance/retard slewing accepted through
// a valid/ready handshake.
module ncoslew #(
  parameter int unsigned N  = 24,
  parameter int unsigned SW = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_slew_valid,
  input  logic                   i_slew_dir,
  input  logic [SW-1:0]          i_slew_amt,
  output logic                   o_slew_ready,
  output logic                   o_slew_done,
  output logic [$clog2(N)-1:0]   o_phase,
  output logic                   o_cq,
  output logic                   o_ci,
  output logic                   o_epoch
);

  localparam int unsigned PW = $clog2(N);

  // Constants sized to the phase arithmetic so comparisons stay width-clean.
  localparam logic [PW:0]   NExt   = (PW+1)'(N);
  localparam logic [PW-1:0] PQuart = PW'(N / 4);
  localparam logic [PW-1:0] PHalf  = PW'(N / 2);
  localparam logic [PW-1:0] P3Quar = PW'((3 * N) / 4);

  logic [PW-1:0] r_p;
  logic [SW-1:0] r_rem;
  logic          r_dir;
  logic          r_epoch;
  logic          r_done;

  logic [PW:0]   w_inc;
  logic [PW:0]   w_sum;
  logic          w_wrap;
  logic [PW-1:0] w_p_next;
  logic          w_ready;
  logic          w_accept;
  logic          w_busy;

  // Step size for this cycle: normal step, double step while advancing, hold while retarding.
  always_comb begin
    w_inc = (PW+1)'(1);
    if (w_busy) begin
      w_inc = r_dir ? (PW+1)'(2) : '0;
    end
  end

  // Modulo-N next phase, computed one bit wider so the wrap is visible.
  always_comb begin
    w_sum    = {1'b0, r_p} + w_inc;
    w_wrap   = (w_sum >= NExt);
    w_p_next = w_wrap ? PW'(w_sum - NExt) : w_sum[PW-1:0];
  end

  assign w_busy   = (r_rem != '0);
  assign w_ready  = !w_busy;
  assign w_accept = i_slew_valid && w_ready;

  // Phase, slew bookkeeping and the two pulse outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p     <= '0;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_epoch <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (i_en) begin
        r_p <= w_p_next;
      end
      // Acceptance only happens with rem == 0, so it never collides with a decrement.
      if (w_accept) begin
        r_rem <= i_slew_amt;
        r_dir <= i_slew_dir;
      end else if (i_en && w_busy) begin
        r_rem <= r_rem - SW'(1);
      end
      r_epoch <= i_en && w_wrap;
      // A zero-length command completes on acceptance, independent of en.
      r_done  <= (i_en && (r_rem == SW'(1))) || (w_accept && (i_slew_amt == '0));
    end
  end

  // Square waves decode from the registered phase only.
  always_comb begin
    o_cq = (r_p < PHalf);
    o_ci = (r_p >= PQuart) && (r_p < P3Quar);
  end

  assign o_phase      = r_p;
  assign o_epoch      = r_epoch;
  assign o_slew_done  = r_done;
  assign o_slew_ready = w_ready;

endmodule

// File: tb/tb_ncoslew.sv
// Randomized scoreboard bench for ncoslew: a tick-accumulator model predicts
// each post-edge output set; a monitor pops and compares after every edge.
module tb_ncoslew;

  localparam int unsigned N  = 24;
  localparam int unsigned SW = 8;
  localparam int unsigned PW = $clog2(N);

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          slew_valid;
  logic          slew_dir;
  logic [SW-1:0] slew_amt;
  logic          slew_ready;
  logic          slew_done;
  logic [PW-1:0] phase;
  logic          cq;
  logic          ci;
  logic          epoch;

  ncoslew #(.N(N), .SW(SW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_slew_valid (slew_valid),
    .i_slew_dir   (slew_dir),
    .i_slew_amt   (slew_amt),
    .o_slew_ready (slew_ready),
    .o_slew_done  (slew_done),
    .o_phase      (phase),
    .o_cq         (cq),
    .o_ci         (ci),
    .o_epoch      (epoch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned ph;
    bit          q;
    bit          i;
    bit          ep;
    bit          dn;
    bit          rdy;
  } exp_t;

  exp_t q_exp[$];
  int   total = 0;
  int   bad   = 0;
  bit   started = 0;

  // Reference model: total ticks elapsed plus the outstanding command.
  longint      m_ticks;
  int unsigned m_left;
  bit          m_adv;

  function automatic exp_t outs(bit ep, bit dn);
    exp_t e;
    int unsigned p;
    p     = int'(m_ticks % N);
    e.ph  = p;
    e.q   = (p < N / 2);
    e.i   = (p >= N / 4) && (p < 3 * N / 4);
    e.ep  = ep;
    e.dn  = dn;
    e.rdy = (m_left == 0);
    return e;
  endfunction

  task automatic model_reset();
    m_ticks = 0;
    m_left  = 0;
    m_adv   = 0;
  endtask

  // One rising edge worth of behaviour, returning the outputs seen after it.
  function automatic exp_t model_step(bit v, bit d, int unsigned amt, bit e);
    longint step;
    bit     ep;
    bit     dn;
    bit     acc;
    acc  = v && (m_left == 0);
    step = 0;
    ep   = 0;
    dn   = 0;
    if (e) begin
      if (m_left == 0) step = 1;
      else step = m_adv ? 2 : 0;
      ep = ((m_ticks % N) + step) >= N;
      if (m_left == 1) dn = 1;
      if (m_left != 0) m_left = m_left - 1;
      m_ticks = m_ticks + step;
    end
    if (acc) begin
      m_left = amt;
      m_adv  = d;
      if (amt == 0) dn = 1;
    end
    return outs(ep, dn);
  endfunction

  task automatic chk(string name, int unsigned got, int unsigned want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
    end
  endtask

  // Monitor: one expected record per rising edge once running.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        if (q_exp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_empty t=%0t got=0 want=1", $time);
        end else begin
          e = q_exp.pop_front();
          chk("phase", phase, e.ph);
          chk("cq", cq, e.q);
          chk("ci", ci, e.i);
          chk("epoch", epoch, e.ep);
          chk("slew_done", slew_done, e.dn);
          chk("slew_ready", slew_ready, e.rdy);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Driver: inputs change on falling edges, expectations pushed at the same time.
  initial begin
    bit          v;
    bit          d;
    bit          e;
    int unsigned amt;
    int unsigned n_rst;
    rst_n      = 1'b0;
    en         = 1'b0;
    slew_valid = 1'b0;
    slew_dir   = 1'b0;
    slew_amt   = '0;
    n_rst      = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_phase", phase, 0);
    chk("rst_cq", cq, 1);
    chk("rst_ci", ci, 0);
    chk("rst_ready", slew_ready, 1);
    rst_n   = 1'b1;
    started = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c >= 1000 && n_rst < 2 && m_left > 3 && (c - 1000) > int'(n_rst) * 800) begin
        // Asynchronous reset in the middle of a pending slew.
        rst_n      = 1'b0;
        slew_valid = 1'b0;
        #1;
        chk("arst_phase", phase, 0);
        chk("arst_cq", cq, 1);
        chk("arst_ci", ci, 0);
        chk("arst_epoch", epoch, 0);
        chk("arst_done", slew_done, 0);
        chk("arst_ready", slew_ready, 1);
        model_reset();
        q_exp.push_back(outs(0, 0));
        n_rst++;
      end else begin
        rst_n = 1'b1;
        if (c < 40) begin
          v = 0;
          e = 1;
        end else begin
          v = ($urandom_range(0, 99) < 30);
          e = ($urandom_range(0, 99) < 85);
        end
        d = $urandom_range(0, 1);
        case ($urandom_range(0, 3))
          0:       amt = 0;
          1:       amt = $urandom_range(1, 3);
          2:       amt = $urandom_range(4, 12);
          default: amt = $urandom_range(13, 40);
        endcase
        // Zero-length commands only with en high.
        if (v && amt == 0) e = 1;
        en         = e;
        slew_valid = v;
        slew_dir   = d;
        slew_amt   = SW'(amt);
        q_exp.push_back(model_step(v, d, amt, e));
      end
      @(negedge clk);
    end
    slew_valid = 1'b0;
    started    = 0;
    @(posedge clk);
    #2;
    if (n_rst == 0) begin
      total++;
      bad++;
      $display("FAIL reset_mid_slew_reached got=0 want=1");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ncoslew.md
# ncoslew

Parametrised one-clock phase generator for the receiver's code/carrier tracking loops: a modulo-N phase counter producing registered quadrature square waves (cq, ci) and an epoch pulse, with multi-step phase slewing (advance or retard by K steps) accepted through a valid/ready handshake. It replaces single-step advance/retard control, letting the loop controller request a whole correction at once and learn when it has been applied.

## Interface
- N, 24: period in clk ticks; multiple of 4, N >= 8.
- SW, 8: width of slew_amt; max slew 2^SW-1 steps per command.
- PW, $clog2(N): width of phase output (derived, not overridden).

- clk  in  1  sole clock, all state on rising edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- en  in  1  count enable; low freezes phase and pauses slewing.
- slew_valid  in  1  slew command offered.
- slew_dir  in  1  1 = advance, 0 = retard; sampled on acceptance.
- slew_amt  in  SW  slew size in steps; sampled on acceptance.
- slew_ready  out  1  high when no slew is pending.
- slew_done  out  1  one-cycle pulse: accepted command fully applied.
- phase  out  PW  current phase p, 0..N-1.
- cq  out  1  high when p < N/2.
- ci  out  1  high when N/4 <= p < 3N/4 (cq delayed a quarter period).
- epoch  out  1  one-cycle pulse registered with the phase update that wraps.

## Operation
- State: p (PW bits), rem (SW bits, steps left), dir (1 bit), epoch, slew_done.
- Per enabled cycle, increment inc: 1 if rem == 0; 2 if rem != 0 and dir = 1; 0 if rem != 0 and dir = 0.
- p <= (p + inc) mod N; computed in PW+1 bits, subtract N when sum >= N.
- epoch <= (p + inc >= N) on enabled cycles, 0 otherwise. Advance from N-1 lands on 1 (skips 0) and still pulses epoch. Retard holding p = 0 does not pulse again.
- rem decrements by 1 on every enabled cycle with rem != 0.
- slew_ready = (rem == 0), combinational from rem only.
- Acceptance: slew_valid && slew_ready at a rising edge loads rem <= slew_amt, dir <= slew_dir. Independent of en.
- slew_done <= 1 when an enabled decrement takes rem 1 -> 0, or on acceptance with slew_amt = 0; else 0.
- A command accepted in the done cycle is legal (ready already high).
- en low: p, rem, dir held; epoch and slew_done forced 0 next edge.
- cq, ci decoded purely from registered p; no input-to-output combinational path except slew_ready from rem.
- Net effect: advance K shortens the current period to N-K ticks; retard K lengthens it to N+K ticks.

## Timing
- Reset (async, rst_n low): p = 0, rem = 0, dir = 0, epoch = 0, slew_done = 0; hence phase = 0, cq = 1, ci = 0, slew_ready = 1.
- Reset mid-slew discards the command; no slew_done is issued.
- Slewing starts the edge after acceptance; first modified update is at acceptance edge + 1.
- K-step slew with en held high: slew_done high in cycle acceptance + K + 1 (the same cycle rem reads 0).
- slew_amt = 0: slew_done high one cycle after acceptance; phase sequence unaffected.
- Outputs valid one cycle after any phase update; cq/ci/epoch change only on clk edges.
- slew_valid with slew_ready low is ignored (not queued); the master holds valid until ready.

## Test plan
- Reset, N=24: release rst_n, en=1 -> phase 0,1,...,23,0; cq high for p 0..11, ci high for p 6..17; epoch every 24 cycles, coincident with phase=0.
- Advance 5 accepted at p=2 -> phase 2,4,6,8,10,12,13,...; slew_done one cycle after the fifth double step; next epoch 19 cycles after the previous one.
- Retard 3 accepted at p=22 -> phase 22,22,22,22,23,0; epoch 27 cycles after the previous one; slew_ready low for 3 cycles, then high with slew_done.
- Advance 1 at p=23 -> phase goes 23 -> 1; epoch pulses on that update; phase 0 never appears that period.
- slew_amt=0 -> slew_done next cycle, slew_ready never drops, phase sequence identical to free run; valid offered while busy -> ignored.
- Retard 4, en low for 3 cycles after 2 steps -> phase and rem frozen, then 2 more held cycles; async rst_n pulse mid-slew -> all outputs at reset values immediately, no slew_done.
